pwm_latch_loader: RTL and testbench
===================================

PWM_LATCH_LOADER -- requirements
Module: pwm_latch_loader

Interface
REQ-001 The block SHALL have parameter NCH_MSB, default 24, giving the highest channel index (NCH_MSB+1 channels).
REQ-002 The block SHALL have parameter TON_MSB, default 10, giving the MSB of the Ton word.
REQ-003 The block SHALL have parameter LATCH_CYC, default 2, giving the latch strobe width in clocks (legal range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, which is the PWM clock domain.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: command present.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-008 The block SHALL have port cmd_chan, input, 5 bits: target channel index.
REQ-009 The block SHALL have port cmd_ton, input, TON_MSB+1 bits: on-time value.
REQ-010 The block SHALL have port cmd_en, input, 1 bit: new output-enable value for the channel.
REQ-011 The block SHALL have port oe_clr, input, 1 bit: global disable, clears every oe bit.
REQ-012 The block SHALL have port ton, output, TON_MSB+1 bits: shared Ton bus to the multi-PWM stage.
REQ-013 The block SHALL have port latch, output, NCH_MSB+1 bits: one-hot per-channel latch strobe.
REQ-014 The block SHALL have port oe, output, NCH_MSB+1 bits: per-channel output enable.
REQ-015 The block SHALL have port busy, output, 1 bit: FIFO non-empty or FSM not IDLE.
REQ-016 The block SHALL have port err_chan, output, 1 bit: one-cycle pulse when a command with an invalid channel is dropped.

Function
REQ-017 The block SHALL hold commands {chan, ton, en} in a 4-entry FIFO; cmd_ready SHALL equal "FIFO not full"; a command is accepted on a clock edge where cmd_valid and cmd_ready are both 1.
REQ-018 A push and a pop on the same edge SHALL both take effect and leave the entry count unchanged; the FIFO SHALL preserve order and wrap its pointers modulo 4.
REQ-019 The FSM SHALL have the states IDLE, SETUP, STROBE and HOLD.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry; a valid entry (chan <= NCH_MSB) SHALL go to SETUP, load ton <= entry.ton and register chan and en.
REQ-021 A popped entry with chan > NCH_MSB SHALL be discarded: the FSM stays in IDLE, err_chan pulses for exactly one cycle, and ton, latch and oe are unchanged.
REQ-022 SETUP SHALL last 1 cycle with latch all zero (Ton setup time), then go to STROBE.
REQ-023 In STROBE, latch SHALL be one-hot at bit chan for exactly LATCH_CYC cycles; oe[chan] SHALL take the value en on the edge entering STROBE.
REQ-024 HOLD SHALL last 1 cycle with latch zero and ton unchanged (hold time), then the FSM goes to IDLE.
REQ-025 ton SHALL change only on the edge entering SETUP and SHALL stay stable while latch is non-zero.
REQ-026 Timing relative to the acceptance edge E, with FIFO empty and FSM IDLE: ton updates at E+2; latch rises at E+3 and falls at E+3+LATCH_CYC; IDLE is re-entered at E+4+LATCH_CYC.
REQ-027 Back-to-back commands SHALL be separated only by that one IDLE cycle: the next SETUP is entered at E+5+LATCH_CYC.
REQ-028 oe_clr SHALL clear all oe bits on the next edge, regardless of state.
REQ-029 If oe_clr coincides with the edge entering STROBE, the clear SHALL win: oe[chan] = 0.
REQ-030 oe_clr SHALL NOT flush the FIFO and SHALL NOT abort the FSM.
REQ-031 At most one latch bit SHALL ever be 1 at a time.

Reset
REQ-032 While reset_n = 0 at a clock edge, the block SHALL set: FIFO empty, FSM = IDLE, ton = 0, latch = 0, oe = 0, err_chan = 0, busy = 0, cmd_ready = 1.
REQ-033 A reset during STROBE SHALL drop latch to 0 on that same edge; any command in flight or queued SHALL be lost.

Verification
REQ-034 Reset with LATCH_CYC=2, then a single command {chan=5, ton=0x3FF, en=1} accepted at E -> ton=0x3FF at E+2; latch=0x0000020 for E+3..E+4; oe=0x0000020; busy falls at E+6.
REQ-035 Push 6 commands back-to-back with the FSM stalled -> cmd_ready drops after 4 accepted; entries are processed in order; spacing is 5 cycles between latch rising edges; no command is lost once cmd_ready is honoured.
REQ-036 Command with chan=25 between two valid commands -> one-cycle err_chan pulse, no latch activity for it, the valid neighbours latch normally.
REQ-037 oe_clr on the same edge as the STROBE entry for {chan=0, en=1} -> oe=0 afterwards; latch[0] still pulses for LATCH_CYC cycles.
REQ-038 reset_n low for 1 cycle mid-STROBE with 3 entries queued -> latch=0 and oe=0 at the next edge; FIFO empty; no further latch pulses.
REQ-039 Simultaneous push and pop at count=4-1 -> count stays at 3; pointer wrap is exercised over 10 or more commands with data integrity checked on ton.

Source files
------------

// File: rtl/pwm_latch_loader.sv
// pwm_latch_loader: queues {chan, ton, en} commands in a 4-entry FIFO and
// replays each one to the multi-PWM stage as a setup / strobe / hold
// sequence on a shared Ton bus with a one-hot per-channel latch strobe.
//
// Command handshake: a command transfers on any rising clk edge where
// cmd_valid and cmd_ready are both 1; cmd_ready is 1 whenever the FIFO has a
// free entry and does not depend on cmd_valid.
module pwm_latch_loader #(
  parameter int NCH_MSB   = 24,
  parameter int TON_MSB   = 10,
  parameter int LATCH_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_chan,
  input  logic [TON_MSB:0] cmd_ton,
  input  logic             cmd_en,
  input  logic             oe_clr,
  output logic [TON_MSB:0] ton,
  output logic [NCH_MSB:0] latch,
  output logic [NCH_MSB:0] oe,
  output logic             busy,
  output logic             err_chan,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam int EW = 5 + TON_MSB + 1 + 1;

  // Command FIFO storage and bookkeeping
  logic [EW-1:0]    fifo_mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic             avail_q;
  logic             push;
  logic             pop;

  logic [4:0]       head_chan;
  logic [TON_MSB:0] head_ton;
  logic             head_en;
  logic             head_valid;

  // Sequencer state
  state_t           state_q;
  state_t           state_d;
  logic [3:0]       cnt_q;
  logic [4:0]       chan_q;
  logic             en_q;
  logic             load;
  logic             drop;
  logic             start_strobe;
  logic [NCH_MSB:0] chan_onehot;

  assign cmd_ready  = (count != 3'd4);
  assign push       = cmd_valid && cmd_ready;
  assign {head_chan, head_ton, head_en} = fifo_mem[rd_ptr];
  assign head_valid = (int'(head_chan) <= NCH_MSB);
  assign busy       = (count != 3'd0) || (state_q != IDLE);
  assign dbg_state  = state_q;

  // Decode the registered channel into its latch bit
  always_comb begin
    chan_onehot = (NCH_MSB + 1)'(1) << chan_q;
  end

  // FIFO entry storage; contents only matter while counted as occupied
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_chan, cmd_ton, cmd_en};
  end

  // FIFO pointers and occupancy; avail_q is the occupancy flag delayed by
  // one clock, which sets the two-clock acceptance-to-setup latency
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count   <= 3'd0;
      avail_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (!push && pop) count <= count - 3'd1;
      avail_q <= (count != 3'd0);
    end
  end

  // Next-state logic: pop in IDLE, then setup, LATCH_CYC strobes, one hold
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    load         = 1'b0;
    drop         = 1'b0;
    start_strobe = 1'b0;
    case (state_q)
      IDLE: begin
        // count is rechecked because avail_q can lag a pop of the last entry
        if (avail_q && (count != 3'd0)) begin
          pop = 1'b1;
          if (head_valid) begin
            load    = 1'b1;
            state_d = SETUP;
          end else begin
            drop = 1'b1;
          end
        end
      end
      SETUP: begin
        start_strobe = 1'b1;
        state_d      = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'(LATCH_CYC - 1)) state_d = HOLD;
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers and the Ton / latch / oe / err outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      chan_q   <= 5'd0;
      en_q     <= 1'b0;
      ton      <= '0;
      latch    <= '0;
      oe       <= '0;
      err_chan <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_chan <= drop;
      if (load) begin
        ton    <= head_ton;
        chan_q <= head_chan;
        en_q   <= head_en;
      end
      if (start_strobe)           cnt_q <= 4'd0;
      else if (state_q == STROBE) cnt_q <= cnt_q + 4'd1;
      latch <= (state_d == STROBE) ? chan_onehot : '0;
      // A global clear wins over the enable update on the strobe-entry edge
      if (oe_clr)            oe <= '0;
      else if (start_strobe) oe <= (oe & ~chan_onehot) | (en_q ? chan_onehot : '0);
    end
  end

endmodule

// File: tb/tb_pwm_latch_loader.sv
// Testbench for pwm_latch_loader: directed timing scenarios plus randomized
// command streams checked against a queue-based reference model.
module tb_pwm_latch_loader;

  localparam int NCH_MSB   = 24;
  localparam int TON_MSB   = 10;
  localparam int LATCH_CYC = 2;
  localparam int NCH       = NCH_MSB + 1;
  localparam int TW        = TON_MSB + 1;
  localparam int W         = 5 + TW + 1;

  logic             clk;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_chan;
  logic [TW-1:0]    cmd_ton;
  logic             cmd_en;
  logic             oe_clr;
  logic [TW-1:0]    ton;
  logic [NCH-1:0]   latch;
  logic [NCH-1:0]   oe;
  logic             busy;
  logic             err_chan;
  logic [1:0]       dbg_state;

  // Scoreboard and reference model state
  logic [W-1:0]     exp_q[$];
  int               rise_cyc_q[$];
  logic [NCH-1:0]   exp_oe;
  int               n_checks;
  int               n_pass;
  int               cyc;
  int               rise_cnt;
  int               rise_at;
  int               err_cycles;
  int               exp_err;
  logic             mon_abort;
  logic             mon_skip_oe;
  logic             stalled;
  logic [NCH-1:0]   prev_latch;
  logic [TW-1:0]    prev_ton;

  pwm_latch_loader #(
    .NCH_MSB  (NCH_MSB),
    .TON_MSB  (TON_MSB),
    .LATCH_CYC(LATCH_CYC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_chan (cmd_chan),
    .cmd_ton  (cmd_ton),
    .cmd_en   (cmd_en),
    .oe_clr   (oe_clr),
    .ton      (ton),
    .latch    (latch),
    .oe       (oe),
    .busy     (busy),
    .err_chan (err_chan),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // Monitor: every latch pulse must match the next expected command
  always @(negedge clk) begin
    logic [W-1:0]   ent;
    logic [4:0]     e_chan;
    logic [TW-1:0]  e_ton;
    logic           e_en;
    logic [NCH-1:0] exp_hot;
    cyc++;
    if (err_chan === 1'b1) err_cycles++;
    if (!mon_abort) begin
      n_checks++;
      if ($countones(latch) > 1) $display("FAIL latch_onehot: got %h expected at most one bit", latch);
      else n_pass++;
      if (latch != '0 && prev_latch == '0) begin
        rise_cnt++;
        rise_cyc_q.push_back(cyc);
        rise_at = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_latch: got %h expected no pulse", latch);
        end else begin
          n_pass++;
          ent    = exp_q.pop_front();
          e_chan = ent[W-1 -: 5];
          e_ton  = ent[TW:1];
          e_en   = ent[0];
          exp_hot = '0;
          exp_hot[e_chan] = 1'b1;
          n_checks++;
          if (latch !== exp_hot) $display("FAIL latch_chan: got %h expected %h", latch, exp_hot);
          else n_pass++;
          n_checks++;
          if (ton !== e_ton) $display("FAIL ton_data: got %h expected %h", ton, e_ton);
          else n_pass++;
          if (!mon_skip_oe) begin
            exp_oe[e_chan] = e_en;
            n_checks++;
            if (oe !== exp_oe) $display("FAIL oe_update: got %h expected %h", oe, exp_oe);
            else n_pass++;
          end
        end
      end else if (latch != '0) begin
        n_checks++;
        if (latch !== prev_latch || ton !== prev_ton)
          $display("FAIL strobe_stable: got latch %h ton %h expected latch %h ton %h", latch, ton, prev_latch, prev_ton);
        else n_pass++;
      end else if (prev_latch != '0) begin
        n_checks++;
        if (cyc - rise_at != LATCH_CYC) $display("FAIL strobe_width: got %0d expected %0d", cyc - rise_at, LATCH_CYC);
        else n_pass++;
      end
    end
    prev_latch = latch;
    prev_ton   = ton;
  end

  // Driver: present one command and hold it until accepted
  task automatic push_cmd(input logic [4:0] chan, input logic [TW-1:0] t, input logic en);
    int g;
    g = 0;
    cmd_chan  = chan;
    cmd_ton   = t;
    cmd_en    = en;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && g < 200) begin
      stalled = 1'b1;
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) begin
      n_checks++;
      $display("FAIL push_timeout: got cmd_ready %b expected 1", cmd_ready);
    end
    @(posedge clk); #1;
    if (int'(chan) <= NCH_MSB) exp_q.push_back({chan, t, en});
    else exp_err++;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    n_checks++;
    if (g >= 500) $display("FAIL idle_timeout_%s: got busy %b expected 0", tag, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b1;
    cmd_chan  = 5'd1;
    cmd_ton   = 11'h155;
    cmd_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ton !== '0)       $display("FAIL reset_ton: got %h expected 0", ton); else n_pass++;
    n_checks++; if (latch !== '0)     $display("FAIL reset_latch: got %h expected 0", latch); else n_pass++;
    n_checks++; if (oe !== '0)        $display("FAIL reset_oe: got %h expected 0", oe); else n_pass++;
    n_checks++; if (err_chan !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_chan); else n_pass++;
    n_checks++; if (busy !== 1'b0)    $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready); else n_pass++;
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    exp_oe    = '0;
    @(posedge clk); #1;
    mon_abort = 1'b0;
  endtask

  // Single command from idle: exact edge-by-edge timing
  task automatic test_single();
    logic [NCH-1:0] hot5;
    hot5 = '0;
    hot5[5] = 1'b1;
    wait_idle("single_pre");
    push_cmd(5'd5, 11'h3FF, 1'b1);                   // now just after E
    @(posedge clk); #1;                               // E+1
    n_checks++; if (ton !== '0) $display("FAIL single_ton_e1: got %h expected 0", ton); else n_pass++;
    @(posedge clk); #1;                               // E+2
    n_checks++; if (ton !== 11'h3FF) $display("FAIL single_ton_e2: got %h expected 3ff", ton); else n_pass++;
    n_checks++; if (latch !== '0) $display("FAIL single_setup_latch: got %h expected 0", latch); else n_pass++;
    @(posedge clk); #1;                               // E+3
    n_checks++; if (latch !== hot5) $display("FAIL single_latch_e3: got %h expected %h", latch, hot5); else n_pass++;
    @(posedge clk); #1;                               // E+4
    n_checks++; if (latch !== hot5) $display("FAIL single_latch_e4: got %h expected %h", latch, hot5); else n_pass++;
    n_checks++; if (oe !== hot5) $display("FAIL single_oe: got %h expected %h", oe, hot5); else n_pass++;
    @(posedge clk); #1;                               // E+5
    n_checks++; if (latch !== '0) $display("FAIL single_latch_e5: got %h expected 0", latch); else n_pass++;
    n_checks++; if (busy !== 1'b1 || ton !== 11'h3FF) $display("FAIL single_hold: got busy %b ton %h expected busy 1 ton 3ff", busy, ton); else n_pass++;
    @(posedge clk); #1;                               // E+6
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_e6: got %b expected 0", busy); else n_pass++;
  endtask

  // Six commands pushed in consecutive cycles
  task automatic test_back_to_back();
    wait_idle("b2b_pre");
    rise_cyc_q.delete();
    stalled = 1'b0;
    for (int i = 0; i < 6; i++)
      push_cmd(5'($urandom_range(0, NCH_MSB)), TW'($urandom), 1'($urandom));
    wait_idle("b2b");
    n_checks++; if (stalled !== 1'b1) $display("FAIL b2b_full: got stall %b expected 1", stalled); else n_pass++;
    n_checks++; if (rise_cyc_q.size() != 6) $display("FAIL b2b_count: got %0d expected 6", rise_cyc_q.size()); else n_pass++;
    for (int i = 1; i < rise_cyc_q.size(); i++) begin
      n_checks++;
      if (rise_cyc_q[i] - rise_cyc_q[i-1] != LATCH_CYC + 3)
        $display("FAIL b2b_spacing: got %0d expected %0d", rise_cyc_q[i] - rise_cyc_q[i-1], LATCH_CYC + 3);
      else n_pass++;
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  // Invalid channel sandwiched between two valid commands
  task automatic test_bad_chan();
    int e0;
    int r0;
    wait_idle("bad_pre");
    e0 = err_cycles;
    r0 = rise_cnt;
    push_cmd(5'd3, TW'($urandom), 1'b1);
    push_cmd(5'd25, TW'($urandom), 1'b1);
    push_cmd(5'd7, TW'($urandom), 1'b0);
    wait_idle("bad");
    n_checks++; if (err_cycles - e0 != 1) $display("FAIL bad_err_pulse: got %0d expected 1", err_cycles - e0); else n_pass++;
    n_checks++; if (rise_cnt - r0 != 2) $display("FAIL bad_latch_count: got %0d expected 2", rise_cnt - r0); else n_pass++;
  endtask

  // oe_clr on the strobe-entry edge, then oe_clr held across a queue
  task automatic test_oe_clr();
    logic [NCH-1:0] hot0;
    int r0;
    hot0 = '0;
    hot0[0] = 1'b1;
    wait_idle("clr_pre");
    mon_skip_oe = 1'b1;
    push_cmd(5'd0, TW'($urandom), 1'b1);             // just after E
    @(posedge clk); #1;                               // E+1
    @(posedge clk); #1;                               // E+2
    oe_clr = 1'b1;
    @(posedge clk); #1;                               // E+3, strobe entry
    oe_clr = 1'b0;
    exp_oe = '0;
    n_checks++; if (oe !== '0) $display("FAIL clr_strobe_oe: got %h expected 0", oe); else n_pass++;
    n_checks++; if (latch !== hot0) $display("FAIL clr_strobe_latch: got %h expected %h", latch, hot0); else n_pass++;
    wait_idle("clr");
    r0 = rise_cnt;
    oe_clr = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(5'($urandom_range(0, NCH_MSB)), TW'($urandom), 1'b1);
    wait_idle("clr_held");
    oe_clr = 1'b0;
    n_checks++; if (rise_cnt - r0 != 3) $display("FAIL clr_no_abort: got %0d expected 3", rise_cnt - r0); else n_pass++;
    n_checks++; if (oe !== '0) $display("FAIL clr_held_oe: got %h expected 0", oe); else n_pass++;
    mon_skip_oe = 1'b0;
  endtask

  // Reset pulse while strobing with three entries queued
  task automatic test_reset_mid();
    int g;
    int r0;
    wait_idle("rst_pre");
    for (int i = 0; i < 4; i++) push_cmd(5'($urandom_range(0, NCH_MSB)), TW'($urandom), 1'b1);
    g = 0;
    while (latch == '0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    n_checks++;
    if (g >= 50) $display("FAIL rst_wait_strobe: got latch %h expected nonzero", latch);
    else n_pass++;
    mon_abort = 1'b1;
    reset_n   = 1'b0;
    @(posedge clk); #1;
    reset_n   = 1'b1;
    n_checks++; if (latch !== '0) $display("FAIL rst_mid_latch: got %h expected 0", latch); else n_pass++;
    n_checks++; if (oe !== '0) $display("FAIL rst_mid_oe: got %h expected 0", oe); else n_pass++;
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rst_mid_fifo: got busy %b ready %b expected 0 1", busy, cmd_ready); else n_pass++;
    exp_q.delete();
    exp_oe = '0;
    @(posedge clk); #1;
    mon_abort = 1'b0;
    r0 = rise_cnt;
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (rise_cnt != r0) $display("FAIL rst_mid_quiet: got %0d pulses expected 0", rise_cnt - r0); else n_pass++;
  endtask

  // Random stream including invalid channels and idle gaps; wraps pointers
  task automatic test_random();
    int e0;
    wait_idle("rand_pre");
    e0 = err_cycles;
    exp_err = 0;
    for (int i = 0; i < 24; i++) begin
      push_cmd(5'($urandom_range(0, 31)), TW'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    wait_idle("rand");
    n_checks++; if (exp_q.size() != 0) $display("FAIL rand_drain: got %0d expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (err_cycles - e0 != exp_err) $display("FAIL rand_err: got %0d expected %0d", err_cycles - e0, exp_err); else n_pass++;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    cyc         = 0;
    rise_cnt    = 0;
    rise_at     = 0;
    err_cycles  = 0;
    exp_err     = 0;
    mon_abort   = 1'b1;
    mon_skip_oe = 1'b0;
    stalled     = 1'b0;
    prev_latch  = '0;
    prev_ton    = '0;
    exp_oe      = '0;
    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_chan    = '0;
    cmd_ton     = '0;
    cmd_en      = 1'b0;
    oe_clr      = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_chan();
    test_oe_clr();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
